// File: rtl/run_detector.sv
// run_detector
//   Serial run/pattern detector for switch/KEY lab tops. One sample is shifted
//   into a DEPTH-bit window on every enabled clock edge. Once the window has
//   been completely filled since the last reset/clear, it is compared against
//   the selected mode: all ones, all zeros, either of those, or a live
//   programmable pattern. The block also tracks:
//   - the length of the current run of equal samples,
//   - a saturating count of match rising edges,
//   - a sticky "ever matched" flag.
//
// Parameters
//   DEPTH        window length in samples (>= 2)
//   CNT_W        width of run_len / match_count (2**CNT_W-1 >= DEPTH)
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous, active-low; clears all state
//   clear        synchronous clear, same effect as reset, overrides enable
//   enable       accept 'in' on this edge
//   in           serial sample
//   mode         00 all-ones, 01 all-zeros, 10 either, 11 pattern
//   pattern      target window for mode 11 (bit DEPTH-1 = oldest)
//   data         window contents, data[0] newest, data[DEPTH-1] oldest
//   valid        window holds DEPTH samples accepted since reset/clear
//   match        window satisfies mode (combinational from registers)
//   match_pulse  one-cycle pulse on the rising edge of match
//   run_len      length of the current run of equal accepted samples
//   match_count  number of match_pulse events, saturating
//   sticky       set on any match, held until reset/clear
module run_detector #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             in,
  input  logic [1:0]       mode,
  input  logic [DEPTH-1:0] pattern,
  output logic [DEPTH-1:0] data,
  output logic             valid,
  output logic             match,
  output logic             match_pulse,
  output logic [CNT_W-1:0] run_len,
  output logic [CNT_W-1:0] match_count,
  output logic             sticky
);

  localparam int               FILL_W    = $clog2(DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  localparam logic [1:0] MODE_ONES    = 2'b00;
  localparam logic [1:0] MODE_ZEROS   = 2'b01;
  localparam logic [1:0] MODE_EITHER  = 2'b10;
  localparam logic [1:0] MODE_PATTERN = 2'b11;

  logic [FILL_W-1:0] fill;
  logic              match_prev;
  logic              window_hit;
  logic              all_ones;
  logic              all_zeros;

  assign all_ones  = &data;
  assign all_zeros = ~|data;

  // Mode and pattern are compared live, so a change while the window is held
  // shows up on match in the same cycle.
  always_comb begin
    window_hit = 1'b0;
    case (mode)
      MODE_ONES:    window_hit = all_ones;
      MODE_ZEROS:   window_hit = all_zeros;
      MODE_EITHER:  window_hit = all_ones | all_zeros;
      MODE_PATTERN: window_hit = (data == pattern);
      default:      window_hit = 1'b0;
    endcase
  end

  // A freshly cleared window of zeros must not match mode 01 before it has
  // actually been filled with samples.
  assign valid       = (fill == FILL_FULL);
  assign match       = valid & window_hit;
  assign match_pulse = match & ~match_prev;

  // Sample window and fill counter; fill saturates once the window is full.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data <= '0;
      fill <= '0;
    end else if (clear) begin
      data <= '0;
      fill <= '0;
    end else if (enable) begin
      data <= {data[DEPTH-2:0], in};
      if (fill != FILL_FULL)
        fill <= fill + 1'b1;
    end
  end

  // Run length: the first sample after reset/clear starts a run of 1,
  // otherwise the run extends while the new sample equals the newest one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_len <= '0;
    end else if (clear) begin
      run_len <= '0;
    end else if (enable) begin
      if (fill == '0)
        run_len <= CNT_W'(1);
      else if (in == data[0]) begin
        if (run_len != CNT_MAX)
          run_len <= run_len + 1'b1;
      end else
        run_len <= CNT_W'(1);
    end
  end

  // Match history runs every clock regardless of enable, so a mode or pattern
  // change on a held window still produces its own pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      match_prev  <= 1'b0;
      match_count <= '0;
      sticky      <= 1'b0;
    end else if (clear) begin
      match_prev  <= 1'b0;
      match_count <= '0;
      sticky      <= 1'b0;
    end else begin
      match_prev <= match;
      sticky     <= sticky | match;
      if (match_pulse && (match_count != CNT_MAX))
        match_count <= match_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_run_detector.sv
// tb_run_detector
//   Self-checking bench for run_detector. Two instances share the same
//   stimulus: one with CNT_W=8 and one with CNT_W=3, so counter saturation is
//   exercised on the narrow copy. Expected outputs come from a sample-history
//   model and are queued after every edge; a monitor pops and compares them.
module tb_run_detector;

  localparam int DEPTH = 4;
  localparam int HIST_MAX = 300;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       enable = 1'b0;
  logic       in = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] pattern = 4'b0000;

  logic [3:0] data8, data3;
  logic       valid8, valid3, match8, match3, pulse8, pulse3, sticky8, sticky3;
  logic [7:0] run_len8, count8;
  logic [2:0] run_len3, count3;

  run_detector #(.DEPTH(DEPTH), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .clear(clear), .enable(enable), .in(in),
    .mode(mode), .pattern(pattern), .data(data8), .valid(valid8),
    .match(match8), .match_pulse(pulse8), .run_len(run_len8),
    .match_count(count8), .sticky(sticky8)
  );

  run_detector #(.DEPTH(DEPTH), .CNT_W(3)) dut_narrow (
    .clock(clock), .reset(reset), .clear(clear), .enable(enable), .in(in),
    .mode(mode), .pattern(pattern), .data(data3), .valid(valid3),
    .match(match3), .match_pulse(pulse3), .run_len(run_len3),
    .match_count(count3), .sticky(sticky3)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] data;
    logic       valid;
    logic       match;
    logic       pulse;
    logic       sticky;
    int         run;
    int         cnt;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   failed = 0;
  bit   done = 1'b0;

  // Model state: history of accepted samples, plus match bookkeeping.
  bit   hist[$];
  int   n_acc = 0;
  bit   prev_m = 1'b0;
  int   cnt = 0;
  bit   stk = 1'b0;

  logic [1:0] cur_mode = 2'b00;
  logic [3:0] cur_pat = 4'b0000;

  function automatic logic [3:0] window();
    logic [3:0] w;
    w = 4'b0000;
    for (int i = 0; i < DEPTH; i++)
      if (hist.size() > i) w[i] = hist[hist.size() - 1 - i];
    return w;
  endfunction

  function automatic bit model_match();
    logic [3:0] w;
    int ones;
    if (n_acc < DEPTH) return 1'b0;
    w = window();
    ones = $countones(w);
    case (cur_mode)
      2'b00:   return ones == DEPTH;
      2'b01:   return ones == 0;
      2'b10:   return (ones == DEPTH) || (ones == 0);
      default: return w == cur_pat;
    endcase
  endfunction

  function automatic int trailing_run();
    int n;
    bit last;
    n = 0;
    if (hist.size() == 0) return 0;
    last = hist[hist.size() - 1];
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != last) break;
      n++;
    end
    return n;
  endfunction

  function automatic void model_reset();
    hist.delete();
    n_acc = 0;
    prev_m = 1'b0;
    cnt = 0;
    stk = 1'b0;
  endfunction

  function automatic void model_edge();
    bit m;
    if (!reset || clear) begin
      model_reset();
      return;
    end
    m = model_match();
    if (m && !prev_m) cnt++;
    stk = stk | m;
    prev_m = m;
    if (enable) begin
      hist.push_back(in);
      if (hist.size() > HIST_MAX) void'(hist.pop_front());
      n_acc++;
    end
  endfunction

  function automatic exp_t make_expected();
    exp_t e;
    e.data   = window();
    e.valid  = (n_acc >= DEPTH);
    e.match  = model_match();
    e.pulse  = e.match && !prev_m;
    e.sticky = stk;
    e.run    = trailing_run();
    e.cnt    = cnt;
    return e;
  endfunction

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic compareAll(input exp_t e);
    checkOutput("data",          32'(data8),    32'(e.data));
    checkOutput("data_narrow",   32'(data3),    32'(e.data));
    checkOutput("valid",         32'(valid8),   32'(e.valid));
    checkOutput("valid_narrow",  32'(valid3),   32'(e.valid));
    checkOutput("match",         32'(match8),   32'(e.match));
    checkOutput("match_narrow",  32'(match3),   32'(e.match));
    checkOutput("pulse",         32'(pulse8),   32'(e.pulse));
    checkOutput("pulse_narrow",  32'(pulse3),   32'(e.pulse));
    checkOutput("sticky",        32'(sticky8),  32'(e.sticky));
    checkOutput("sticky_narrow", 32'(sticky3),  32'(e.sticky));
    checkOutput("run_len",       32'(run_len8), 32'(sat(e.run, 255)));
    checkOutput("run_len_narrow",32'(run_len3), 32'(sat(e.run, 7)));
    checkOutput("count",         32'(count8),   32'(sat(e.cnt, 255)));
    checkOutput("count_narrow",  32'(count3),   32'(sat(e.cnt, 7)));
  endtask

  // One clock: drive at the falling edge, update the model on the rising edge
  // and queue what the DUT should show after it.
  task automatic applyStimulus(input logic en, input logic b, input logic clr);
    @(negedge clock);
    enable  = en;
    in      = b;
    clear   = clr;
    mode    = cur_mode;
    pattern = cur_pat;
    @(posedge clock);
    model_edge();
    sb.push_back(make_expected());
  endtask

  // Reset pulse placed between edges; outputs must clear without a clock.
  task automatic asyncReset();
    @(negedge clock);
    enable = 1'b0;
    clear  = 1'b0;
    #2 reset = 1'b0;
    model_reset();
    #1 compareAll(make_expected());
    #1 reset = 1'b1;
  endtask

  // Monitor: every rising edge with a queued expectation is checked.
  initial begin
    exp_t e;
    while (!done) begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        compareAll(e);
      end
    end
  end

  initial begin
    model_reset();
    #12 reset = 1'b1;

    // All-zeros window becomes valid only on the fourth sample.
    cur_mode = 2'b01;
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // All-ones run of six.
    cur_mode = 2'b00;
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (6) applyStimulus(1'b1, 1'b1, 1'b0);

    // Pattern 1011 then one more sample breaks it.
    cur_mode = 2'b11;
    cur_pat  = 4'b1011;
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);

    // Hold for five clocks, then clear beats an enabled sample.
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);

    // Held matched window with mode toggled 00 -> 01 -> 00.
    cur_mode = 2'b00;
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b0);
    cur_mode = 2'b01;
    applyStimulus(1'b0, 1'b0, 1'b0);
    cur_mode = 2'b00;
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Nine ones saturate the narrow run counter, then async reset mid-run.
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (9) applyStimulus(1'b1, 1'b1, 1'b0);
    asyncReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);

    // Long run saturates the wide run counter; mode toggling saturates counts.
    cur_mode = 2'b10;
    repeat (262) applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 520; i++) begin
      cur_mode = (i % 2 == 0) ? 2'b01 : 2'b00;
      applyStimulus(1'b0, 1'b1, 1'b0);
    end

    // Randomized traffic with sticky runs and live mode/pattern changes.
    applyStimulus(1'b0, 1'b0, 1'b1);
    begin
      logic b;
      b = 1'b0;
      for (int i = 0; i < 2500; i++) begin
        if ($urandom_range(0, 99) < 25) b = ~b;
        if ($urandom_range(0, 99) < 5) cur_mode = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 99) < 5) cur_pat = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 999) < 5)
          asyncReset();
        else
          applyStimulus(($urandom_range(0, 99) < 75), b, ($urandom_range(0, 99) < 2));
      end
    end

    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clock);
    #2;
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
